// File: rtl/eedc_pkg.sv
// Shared constants and reference encode function for the EEDC Hamming(11,7) encoder/decoder pair.
package eedc_pkg;

   localparam int DATA_W = 7;
   localparam int PAR_W  = 4;
   localparam int CODE_W = 11;

   // 1-based codeword positions of the parity bits P1, P2, P4, P8
   localparam logic [3:0] PAR_POS  [PAR_W]  = '{4'd1, 4'd2, 4'd4, 4'd8};
   // 1-based codeword positions of d0..d6
   localparam logic [3:0] DATA_POS [DATA_W] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};

   function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
      logic p1, p2, p4, p8;
      p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      p4 = d[1] ^ d[2] ^ d[3];
      p8 = d[4] ^ d[5] ^ d[6];
      return {d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

endpackage

// File: rtl/eedc_encoder_if.sv
// Data-in / codeword-out bundle between a data source and the EEDC encoder.
interface eedc_encoder_if;
   import eedc_pkg::*;

   logic [DATA_W-1:0] data_input;
   logic [CODE_W-1:0] encoded_output;

   modport master (output data_input, input encoded_output);
   modport slave  (input data_input, output encoded_output);
endinterface

// File: rtl/eedc_parity_gen.sv
// Combinational even-parity generator: p[0..3] = P1, P2, P4, P8 of the data word.
module eedc_parity_gen
   import eedc_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   output logic [PAR_W-1:0]  p
);

   always_comb begin
      p    = '0;
      p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      p[2] = d[1] ^ d[2] ^ d[3];
      p[3] = d[4] ^ d[5] ^ d[6];
   end

endmodule

// File: rtl/eedc_encoder.sv
// Hamming(11,7) encoder: merges data and parity into the codeword layout and registers it.
module eedc_encoder
   import eedc_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   eedc_encoder_if.slave bus
);

   logic [PAR_W-1:0]  par;
   logic [CODE_W-1:0] code_d;
   logic [CODE_W-1:0] code_q;

   eedc_parity_gen u_parity_gen (
      .d (bus.data_input),
      .p (par)
   );

   // Bit p-1 carries codeword position p; parity sits at the power-of-two positions
   always_comb begin
      code_d = {bus.data_input[6:4], par[3], bus.data_input[3:1], par[2],
                bus.data_input[0], par[1:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= '0;
      end else begin
         code_q <= code_d;
      end
   end

   assign bus.encoded_output = code_q;

endmodule

// File: tb/tb_eedc_encoder.sv
// Directed and exhaustive self-checking bench for the Hamming(11,7) encoder.
module tb_eedc_encoder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   eedc_encoder_if bus_if ();

   eedc_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic Hamming construction: place data at non-power-of-two positions,
   // then each parity bit k is the XOR of every position with bit k set.
   function automatic logic [10:0] model_enc(input logic [6:0] d);
      logic [10:0] c;
      int di;
      c  = '0;
      di = 0;
      for (int pos = 1; pos <= 11; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos-1] = d[di];
            di++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         logic par;
         par = 1'b0;
         for (int pos = 1; pos <= 11; pos++) begin
            if (((pos >> k) & 1) == 1) par = par ^ c[pos-1];
         end
         c[(1 << k) - 1] = par;
      end
      return c;
   endfunction

   function automatic logic [3:0] syndrome(input logic [10:0] c);
      logic [3:0] s;
      s = '0;
      for (int pos = 1; pos <= 11; pos++) begin
         if (c[pos-1]) s = s ^ 4'(pos);
      end
      return s;
   endfunction

   task automatic test_reset();
      bus_if.data_input = 7'b1011011;
      @(posedge clk); #1;
      checks++;
      if (bus_if.encoded_output !== 11'b10101010111) begin
         errors++;
         $display("FAIL pre_reset_load: got %b expected %b", bus_if.encoded_output, 11'b10101010111);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.encoded_output !== 11'b0) begin
         errors++;
         $display("FAIL async_reset_assert: got %b expected %b", bus_if.encoded_output, 11'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus_if.encoded_output !== 11'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", bus_if.encoded_output, 11'b0);
      end
   endtask

   task automatic test_reset_release();
      @(negedge clk);
      bus_if.data_input = 7'b1001001;
      #2;
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus_if.encoded_output !== 11'b0) begin
         errors++;
         $display("FAIL release_before_edge: got %b expected %b", bus_if.encoded_output, 11'b0);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_if.encoded_output !== 11'b10011001111) begin
         errors++;
         $display("FAIL release_first_edge: got %b expected %b", bus_if.encoded_output, 11'b10011001111);
      end
   endtask

   task automatic test_vectors();
      logic [6:0]  vin  [5];
      logic [10:0] vexp [5];
      vin[0] = 7'b0000000; vexp[0] = 11'b00000000000;
      vin[1] = 7'b0000001; vexp[1] = 11'b00000000111;
      vin[2] = 7'b0000010; vexp[2] = 11'b00000011001;
      vin[3] = 7'b1001001; vexp[3] = 11'b10011001111;
      vin[4] = 7'b1011011; vexp[4] = 11'b10101010111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus_if.data_input = vin[i];
         @(posedge clk); #1;
         checks++;
         if (bus_if.encoded_output !== vexp[i]) begin
            errors++;
            $display("FAIL vector_%0d: data %b got %b expected %b", i, vin[i], bus_if.encoded_output, vexp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  seq_in  [4];
      logic [10:0] seq_exp [4];
      seq_in[0] = 7'b0000001; seq_exp[0] = 11'b00000000111;
      seq_in[1] = 7'b1011011; seq_exp[1] = 11'b10101010111;
      seq_in[2] = 7'b0000010; seq_exp[2] = 11'b00000011001;
      seq_in[3] = 7'b1001001; seq_exp[3] = 11'b10011001111;
      @(negedge clk);
      bus_if.data_input = seq_in[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus_if.encoded_output !== seq_exp[i]) begin
            errors++;
            $display("FAIL b2b_%0d: got %b expected %b", i, bus_if.encoded_output, seq_exp[i]);
         end
         // A mid-cycle input change must not show before the next edge
         bus_if.data_input = (i < 3) ? seq_in[i+1] : 7'b0000000;
         #2;
         checks++;
         if (bus_if.encoded_output !== seq_exp[i]) begin
            errors++;
            $display("FAIL b2b_hold_%0d: got %b expected %b", i, bus_if.encoded_output, seq_exp[i]);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [10:0] got;
      logic [10:0] flipped;
      logic [3:0]  syn;
      for (int v = 0; v < 128; v++) begin
         @(negedge clk);
         bus_if.data_input = 7'(v);
         @(posedge clk); #1;
         got = bus_if.encoded_output;
         checks++;
         if (got !== model_enc(7'(v))) begin
            errors++;
            $display("FAIL exh_code_%0d: got %b expected %b", v, got, model_enc(7'(v)));
         end
         checks++;
         syn = syndrome(got);
         if (syn !== 4'd0) begin
            errors++;
            $display("FAIL exh_syndrome_%0d: got %0d expected 0", v, syn);
         end
         if (v != 0) begin
            checks++;
            if ($countones(got) < 3) begin
               errors++;
               $display("FAIL exh_weight_%0d: got %0d expected >=3", v, $countones(got));
            end
         end
         for (int b = 0; b < 11; b++) begin
            flipped = got;
            flipped[b] = ~flipped[b];
            syn = syndrome(flipped);
            checks++;
            if (syn !== 4'(b + 1)) begin
               errors++;
               $display("FAIL exh_flip_%0d_bit%0d: got %0d expected %0d", v, b, syn, b + 1);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_if.data_input = 7'b0000000;
      #1;
      checks++;
      if (bus_if.encoded_output !== 11'b0) begin
         errors++;
         $display("FAIL power_on_reset: got %b expected %b", bus_if.encoded_output, 11'b0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      test_reset();
      test_reset_release();
      test_vectors();
      test_back_to_back();
      test_exhaustive();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
